// File: rtl/pin_array_pkg.sv
// Shared types and constants for the pin_array_debounce block.
package pin_array_pkg;

  typedef enum logic [1:0] {
    MODE_OR  = 2'd0,
    MODE_AND = 2'd1,
    MODE_XOR = 2'd2,
    MODE_MAJ = 2'd3
  } pin_mode_e;

  localparam int unsigned GLITCH_CNT_W = 16;

endpackage

// File: rtl/pin_debounce.sv
// One pin: synchroniser chain, debounce counter and stable flop.
// abort_c flags an edge where a partial count is discarded because the pin returned to its stable value.
module pin_debounce
  import pin_array_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic pin_in,
  output logic stable,
  output logic abort_c
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   sync;

  assign sync   = sync_q[SYNC_STAGES-1];
  assign stable = stable_q;

  // Counter runs only while enabled; it is forced to zero otherwise.
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], pin_in};
    cnt_d    = '0;
    stable_d = stable_q;
    abort_c  = 1'b0;
    if (en) begin
      if (sync == stable_q) begin
        abort_c = (cnt_q != '0);
      end else if (cnt_q < CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        stable_d = sync;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

endmodule

// File: rtl/pin_array_debounce.sv
// N-pin debounce array with a mode-selectable registered reduction and change strobe.
// Define PIN_ARRAY_GLITCH_CNT_EN to add the saturating glitch_cnt output.
module pin_array_debounce
  import pin_array_pkg::*;
#(
  parameter int unsigned NUM_PINS        = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    VDD,
  input  logic                    VSS,
  input  logic                    en,
  input  logic [1:0]              mode,
  input  logic [NUM_PINS-1:0]     vin,
  output logic [NUM_PINS-1:0]     vin_stable,
`ifdef PIN_ARRAY_GLITCH_CNT_EN
  output logic [GLITCH_CNT_W-1:0] glitch_cnt,
`endif
  output logic                    vout,
  output logic                    change_pulse
);

  localparam int unsigned POP_W = $clog2(NUM_PINS + 1);

  logic [NUM_PINS-1:0] abort_c;
  logic [NUM_PINS-1:0] stable_prev_q, stable_prev_d;
  logic                vout_q, vout_d;
  logic                change_pulse_q, change_pulse_d;
  logic [POP_W-1:0]    pop_c;
  logic                unused_supply;

  // Supply pins are carried for netlist compatibility only.
  assign unused_supply = VDD ^ VSS;

  for (genvar g = 0; g < NUM_PINS; g++) begin : g_pin
    pin_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_pin (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .pin_in  (vin[g]),
      .stable  (vin_stable[g]),
      .abort_c (abort_c[g])
    );
  end

  // Reduction of the debounced pins; majority ties resolve to 0.
  always_comb begin
    pop_c = '0;
    for (int i = 0; i < NUM_PINS; i++) begin
      pop_c = pop_c + POP_W'(vin_stable[i]);
    end
    vout_d = 1'b0;
    case (pin_mode_e'(mode))
      MODE_OR:  vout_d = |vin_stable;
      MODE_AND: vout_d = &vin_stable;
      MODE_XOR: vout_d = ^vin_stable;
      MODE_MAJ: vout_d = (pop_c > POP_W'(NUM_PINS / 2));
      default:  vout_d = 1'b0;
    endcase
    stable_prev_d  = vin_stable;
    change_pulse_d = |(vin_stable ^ stable_prev_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_prev_q  <= '0;
      vout_q         <= 1'b0;
      change_pulse_q <= 1'b0;
    end else begin
      stable_prev_q  <= stable_prev_d;
      vout_q         <= vout_d;
      change_pulse_q <= change_pulse_d;
    end
  end

  assign vout         = vout_q;
  assign change_pulse = change_pulse_q;

`ifdef PIN_ARRAY_GLITCH_CNT_EN
  logic [GLITCH_CNT_W-1:0] glitch_q, glitch_d;

  // One count per edge with any aborted pin, saturating at all-ones.
  always_comb begin
    glitch_d = glitch_q;
    if ((|abort_c) && (glitch_q != '1)) begin
      glitch_d = glitch_q + GLITCH_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glitch_q <= '0;
    end else begin
      glitch_q <= glitch_d;
    end
  end

  assign glitch_cnt = glitch_q;
`else
  logic unused_abort;
  assign unused_abort = |abort_c;
`endif

endmodule

// File: tb/tb_pin_array_debounce.sv
// Directed self-checking bench for pin_array_debounce at default parameters.
module tb_pin_array_debounce;

  logic       clk;
  logic       rst_n;
  logic       VDD;
  logic       VSS;
  logic       en;
  logic [1:0] mode;
  logic [3:0] vin;
  logic [3:0] vin_stable;
  logic       vout;
  logic       change_pulse;
`ifdef PIN_ARRAY_GLITCH_CNT_EN
  logic [15:0] glitch_cnt;
`endif

  int vectors;
  int miscompares;

  pin_array_debounce dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .VDD          (VDD),
    .VSS          (VSS),
    .en           (en),
    .mode         (mode),
    .vin          (vin),
    .vin_stable   (vin_stable),
`ifdef PIN_ARRAY_GLITCH_CNT_EN
    .glitch_cnt   (glitch_cnt),
`endif
    .vout         (vout),
    .change_pulse (change_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    VDD   = 1'b1;
    VSS   = 1'b0;
    rst_n = 1'b0;
    en    = 1'b0;
    mode  = 2'b00;
    vin   = 4'b0000;

    // 1: reset state and every mode on all-zero pins
    tick();
    tick();
    chk("rst_stable", 32'(vin_stable), 32'h0);
    chk("rst_vout", 32'(vout), 32'h0);
    chk("rst_pulse", 32'(change_pulse), 32'h0);
    rst_n = 1'b1;
    for (int m = 0; m < 4; m++) begin
      mode = 2'(m);
      tick();
      chk("zero_vout", 32'(vout), 32'h0);
      chk("zero_pulse", 32'(change_pulse), 32'h0);
    end

    // 2: single pin rise, OR mode, S+D latency
    en   = 1'b1;
    mode = 2'b00;
    vin  = 4'b0001;
    repeat (9) tick();
    chk("lat_e9_stable", 32'(vin_stable), 32'h0);
    tick();
    chk("lat_e10_stable", 32'(vin_stable), 32'h1);
    chk("lat_e10_vout", 32'(vout), 32'h0);
    chk("lat_e10_pulse", 32'(change_pulse), 32'h0);
    tick();
    chk("lat_e11_vout", 32'(vout), 32'h1);
    chk("lat_e11_pulse", 32'(change_pulse), 32'h1);
    tick();
    chk("lat_e12_pulse", 32'(change_pulse), 32'h0);

    // 3: five-cycle glitch on pin 1 is rejected
    vin = 4'b0011;
    repeat (5) tick();
    vin = 4'b0001;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("glitch_stable", 32'(vin_stable), 32'h1);
      chk("glitch_pulse", 32'(change_pulse), 32'h0);
    end
`ifdef PIN_ARRAY_GLITCH_CNT_EN
    chk("glitch_cnt", 32'(glitch_cnt), 32'h1);
`endif

    // 4: reduction sweep on 0111, then majority tie on 0011
    vin = 4'b0111;
    repeat (12) tick();
    chk("sweep_stable", 32'(vin_stable), 32'h7);
    mode = 2'b00; tick(); chk("sweep_or", 32'(vout), 32'h1);
    mode = 2'b01; tick(); chk("sweep_and", 32'(vout), 32'h0);
    mode = 2'b10; tick(); chk("sweep_xor", 32'(vout), 32'h1);
    mode = 2'b11; tick(); chk("sweep_maj", 32'(vout), 32'h1);
    vin = 4'b0011;
    repeat (12) tick();
    chk("tie_stable", 32'(vin_stable), 32'h3);
    mode = 2'b00; tick(); chk("tie_or", 32'(vout), 32'h1);
    mode = 2'b11; tick(); chk("tie_maj", 32'(vout), 32'h0);

    // 5: async reset, then en=0 holds while inputs settle
    rst_n = 1'b0;
    en    = 1'b0;
    vin   = 4'b1111;
    #2;
    chk("async_stable", 32'(vin_stable), 32'h0);
    chk("async_vout", 32'(vout), 32'h0);
    tick();
    rst_n = 1'b1;
    repeat (20) tick();
    chk("dis_stable", 32'(vin_stable), 32'h0);
    chk("dis_vout", 32'(vout), 32'h0);
    en = 1'b1;
    repeat (7) tick();
    chk("reen_e7_stable", 32'(vin_stable), 32'h0);
    tick();
    chk("reen_e8_stable", 32'(vin_stable), 32'hF);
    tick();
    chk("reen_vout", 32'(vout), 32'h1);
    chk("reen_pulse", 32'(change_pulse), 32'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("reen_one_pulse", 32'(change_pulse), 32'h0);
    end

    // 6: reset mid-debounce discards the partial count
    rst_n = 1'b0;
    mode  = 2'b00;
    vin   = 4'b1000;
    #2;
    chk("mid_rst_stable", 32'(vin_stable), 32'h0);
    chk("mid_rst_vout", 32'(vout), 32'h0);
    chk("mid_rst_pulse", 32'(change_pulse), 32'h0);
    tick();
    rst_n = 1'b1;
    repeat (7) tick();
    rst_n = 1'b0;
    #2;
    chk("mid_rst2_stable", 32'(vin_stable), 32'h0);
    tick();
    rst_n = 1'b1;
    repeat (9) tick();
    chk("relat_e9_stable", 32'(vin_stable), 32'h0);
    tick();
    chk("relat_e10_stable", 32'(vin_stable), 32'h8);
    tick();
    chk("relat_vout", 32'(vout), 32'h1);
    chk("relat_pulse", 32'(change_pulse), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
